data_ram: RTL and testbench
===========================

DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter ADSize, default 4, address width in bits.
REQ-002 Parameter DASize, default 16, data word width in bits.
REQ-003 Parameter RAMSize, default 16, number of storage words; legal range 1 to 2^ADSize.
REQ-004 clk  input  1  single clock; all state changes on rising edge except reset.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en_read  input  1  read enable, sampled at rising clk.
REQ-007 en_write  input  1  write enable, sampled at rising clk.
REQ-008 addr  input  ADSize  word address shared by read and write.
REQ-009 DMin  input  DASize  write data.
REQ-010 DMout  output  DASize  registered read data.

Function
REQ-011 Storage SHALL be an array named RAM_Data of RAMSize words of DASize bits, indices 0..RAMSize-1, hierarchically accessible for bench inspection.
REQ-012 Write: at rising clk with en_write=1, rst=0 and addr<RAMSize, RAM_Data[addr] SHALL take DMin.
REQ-013 Read: at rising clk with en_read=1, rst=0 and addr<RAMSize, DMout SHALL take RAM_Data[addr]; one-cycle latency, value visible after that edge.
REQ-014 With en_read=0, DMout SHALL hold its previous value.
REQ-015 With en_write=0, no storage word SHALL change.
REQ-016 Out of range (addr>=RAMSize): write ignored; read loads DMout with 0.
REQ-017 Simultaneous en_read=1 and en_write=1 on the same address SHALL perform the write and, by default, return the pre-write (old) word on DMout.
REQ-018 Simultaneous read/write on different addresses SHALL perform both independently in the same cycle.
REQ-019 No handshake, no stall; one operation of each kind is accepted every cycle.

Reset
REQ-020 rst=1 SHALL immediately, without a clock edge, clear DMout and every RAM_Data word to 0.
REQ-021 While rst=1, en_read and en_write SHALL be ignored; a write in flight when reset asserts is discarded.
REQ-022 The first operation after release SHALL be taken at the first rising clk with rst=0.

Configuration
REQ-023 Macro DATA_RAM_WRITE_THROUGH_EN defined: on simultaneous read and write to the same in-range address, DMout SHALL take DMin (new data).
REQ-024 Macro DATA_RAM_WRITE_THROUGH_EN undefined: behaviour per REQ-017 (old data); all other behaviour identical in both builds.

Verification
REQ-025 Assert rst one cycle with all enables low -> DMout=0x0000 and RAM_Data[0..15]=0x0000.
REQ-026 Release rst; write addr 0..6 with DMin 1..7 (one per cycle, en_write=1) -> RAM_Data[0..6]=0x0001..0x0007, RAM_Data[7..15]=0x0000.
REQ-027 Then read addr 1..7 one per cycle with en_read=1, en_write=0, DMin driven to junk -> DMout sequence 0x0002..0x0007 then 0x0000, each one cycle after its address; no storage word changes.
REQ-028 After reading addr 3 (DMout=0x0004), drop en_read and change addr to 5 -> DMout stays 0x0004.
REQ-029 RAM_Data[2]=0x0003; en_read=en_write=1, addr=2, DMin=0x00AA -> DMout=0x0003 (0x00AA with DATA_RAM_WRITE_THROUGH_EN); RAM_Data[2]=0x00AA afterwards.
REQ-030 Assert rst mid-cycle between edges during a write burst -> DMout and all words read 0x0000 before the next rising clk; the pending write does not occur.

Source files
------------

// File: rtl/data_ram.sv
// Single-port-address synchronous data RAM with registered read data and async clear.
// Optional DATA_RAM_WRITE_THROUGH_EN: same-cycle read+write returns the new data.
module data_ram #(
    parameter int unsigned ADSize  = 4,
    parameter int unsigned DASize  = 16,
    parameter int unsigned RAMSize = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_read,
    input  logic              en_write,
    input  logic [ADSize-1:0] addr,
    input  logic [DASize-1:0] DMin,
    output logic [DASize-1:0] DMout
);

    // One extra bit so RAMSize == 2**ADSize still compares correctly.
    localparam int unsigned AW_EXT = ADSize + 1;

    logic [DASize-1:0] RAM_Data [RAMSize];
    logic [DASize-1:0] dmout_q;
    logic [DASize-1:0] dmout_d;
    logic              in_range_c;
    logic              wr_en_c;

    always_comb begin
        in_range_c = ({1'b0, addr} < AW_EXT'(RAMSize));
        wr_en_c    = en_write && in_range_c;
        dmout_d    = dmout_q;
        if (en_read) begin
            if (!in_range_c) begin
                dmout_d = '0;
            end else begin
`ifdef DATA_RAM_WRITE_THROUGH_EN
                dmout_d = en_write ? DMin : RAM_Data[addr];
`else
                dmout_d = RAM_Data[addr];
`endif
            end
        end
    end

    // Reset clears the whole array so nothing stale survives an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmout_q <= '0;
            for (int i = 0; i < int'(RAMSize); i++) begin
                RAM_Data[i] <= '0;
            end
        end else begin
            dmout_q <= dmout_d;
            if (wr_en_c) begin
                RAM_Data[addr] <= DMin;
            end
        end
    end

    assign DMout = dmout_q;

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: a full 16-word instance plus a 12-word instance
// sharing stimulus so out-of-range behaviour is visible.
module tb_data_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_read;
    logic        en_write;
    logic [3:0]  addr;
    logic [15:0] DMin;
    logic [15:0] DMout;
    logic [15:0] DMout_s;
    logic        chk_en;

    typedef struct {
        logic [15:0] e;
        logic [15:0] es;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem_m [16];
    logic [15:0] mem_s [12];
    int          checks = 0;
    int          fails  = 0;

`ifdef DATA_RAM_WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif

    data_ram #(.ADSize(4), .DASize(16), .RAMSize(16)) dut (
        .clk(clk), .rst(rst), .en_read(en_read), .en_write(en_write),
        .addr(addr), .DMin(DMin), .DMout(DMout)
    );

    data_ram #(.ADSize(4), .DASize(16), .RAMSize(12)) u_small (
        .clk(clk), .rst(rst), .en_read(en_read), .en_write(en_write),
        .addr(addr), .DMin(DMin), .DMout(DMout_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
        for (int i = 0; i < 12; i++) mem_s[i] = 16'h0000;
    endtask

    task automatic chk_ram(input string tag);
        for (int i = 0; i < 16; i++) check($sformatf("%s_big[%0d]", tag, i), dut.RAM_Data[i], mem_m[i]);
        for (int i = 0; i < 12; i++) check($sformatf("%s_small[%0d]", tag, i), u_small.RAM_Data[i], mem_s[i]);
    endtask

    // Drive one cycle's inputs (caller sits at a negedge), then move to the next negedge.
    task automatic cyc(input logic rd, input logic wr, input logic [3:0] a, input logic [15:0] d,
                       input bit chk, input logic [15:0] e, input logic [15:0] es);
        en_read  = rd;
        en_write = wr;
        addr     = a;
        DMin     = d;
        chk_en   = chk;
        if (chk) sb.push_back('{e: e, es: es});
        if (wr) begin
            mem_m[a] = d;
            if (a < 4'd12) mem_s[a] = d;
        end
        @(negedge clk);
    endtask

    // Monitor: a checked read taken at a posedge is compared at the following negedge.
    initial begin
        bit   pend;
        exp_t x;
        forever begin
            @(posedge clk);
            pend = chk_en;
            @(negedge clk);
            if (pend) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sb_underflow: got output with no expected entry");
                end else begin
                    x = sb.pop_front();
                    check("dmout_big", DMout, x.e);
                    check("dmout_small", DMout_s, x.es);
                end
            end
        end
    end

    initial begin
        logic [15:0] rd_exp [7];
        rd_exp = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0000};

        rst = 1'b1; en_read = 1'b0; en_write = 1'b0; addr = 4'h0; DMin = 16'h0000; chk_en = 1'b0;
        clear_models();
        #3;
        check("rst_dmout_big", DMout, 16'h0000);
        check("rst_dmout_small", DMout_s, 16'h0000);
        chk_ram("rst");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 4'(i), 16'(i + 1), 1'b0, 16'h0, 16'h0);
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        chk_ram("wr");

        for (int i = 1; i <= 7; i++) cyc(1'b1, 1'b0, 4'(i), 16'hDEAD, 1'b1, rd_exp[i-1], rd_exp[i-1]);
        cyc(1'b0, 1'b0, 4'h0, 16'hBEEF, 1'b0, 16'h0, 16'h0);
        chk_ram("rd");

        cyc(1'b1, 1'b0, 4'h3, 16'h0, 1'b1, 16'h0004, 16'h0004);
        cyc(1'b0, 1'b0, 4'h5, 16'h0, 1'b1, 16'h0004, 16'h0004);
        cyc(1'b0, 1'b0, 4'h5, 16'h0, 1'b1, 16'h0004, 16'h0004);

        cyc(1'b1, 1'b1, 4'h2, 16'h00AA, 1'b1, WT ? 16'h00AA : 16'h0003, WT ? 16'h00AA : 16'h0003);
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        chk_ram("same_addr");
        cyc(1'b1, 1'b0, 4'h2, 16'h0, 1'b1, 16'h00AA, 16'h00AA);

        // Addresses 12..15 are out of range for the small instance only.
        cyc(1'b0, 1'b1, 4'hD, 16'h0055, 1'b0, 16'h0, 16'h0);
        cyc(1'b1, 1'b0, 4'hD, 16'h0, 1'b1, 16'h0055, 16'h0000);
        cyc(1'b1, 1'b0, 4'h6, 16'h0, 1'b1, 16'h0007, 16'h0007);
        cyc(1'b1, 1'b0, 4'hC, 16'h0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b1, 1'b0, 4'h6, 16'h0, 1'b1, 16'h0007, 16'h0007);
        cyc(1'b1, 1'b1, 4'hE, 16'h0066, 1'b1, WT ? 16'h0066 : 16'h0000, 16'h0000);
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        chk_ram("oor");

        cyc(1'b0, 1'b1, 4'h8, 16'h0011, 1'b0, 16'h0, 16'h0);
        cyc(1'b0, 1'b1, 4'h9, 16'h0022, 1'b0, 16'h0, 16'h0);
        en_write = 1'b1; addr = 4'hA; DMin = 16'h0033; chk_en = 1'b0;
        #2 rst = 1'b1;
        clear_models();
        #1;
        check("midrst_dmout_big", DMout, 16'h0000);
        check("midrst_dmout_small", DMout_s, 16'h0000);
        chk_ram("midrst");
        @(posedge clk);
        #1;
        chk_ram("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        cyc(1'b1, 1'b1, 4'h4, 16'h0077, 1'b1, WT ? 16'h0077 : 16'h0000, WT ? 16'h0077 : 16'h0000);
        cyc(1'b1, 1'b0, 4'h4, 16'h0, 1'b1, 16'h0077, 16'h0077);
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        chk_ram("post_rst");

        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d pending entries expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
